// File: rtl/if_id_fetch_ctrl_pkg.sv
// Shared core definitions: opcode constants, the NOP encoding and the fetch FSM
// state encoding, which the hazard unit debug logic also uses.
package if_id_fetch_ctrl_pkg;

    localparam logic [3:0]  OP_HLT   = 4'hF;
    localparam logic [3:0]  OP_LHB   = 4'hA;
    localparam logic [3:0]  OP_LLB   = 4'hB;
    localparam logic [3:0]  OP_SW    = 4'h9;
    localparam logic [15:0] CORE_NOP = 16'h0000;   // ADD r0,r0,r0

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    function automatic logic has_opcode(input logic [15:0] instr, input logic [3:0] op);
        return instr[15:12] == op;
    endfunction

endpackage

// File: rtl/if_id_fetch_ctrl_dff.sv
// Enabled register cell with synchronous active-low reset to a fixed value.
module dff #(
    parameter int         W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/if_id_fetch_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (en && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/if_id_fetch_ctrl.sv
// Fetch-side controller: owns the PC and IF/ID register, honours hazard-unit stall/halt,
// squashes on taken branches and drains with NOPs after fetching HLT.
module if_id_fetch_ctrl
    import if_id_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = CORE_NOP,
    parameter logic [3:0]  HLT_OPCODE = OP_HLT,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             hlt_in,
    input  logic             branch_taken,
    input  logic [15:0]      branch_target,
    input  logic [15:0]      imem_instr,
    output logic [15:0]      imem_addr,
    output logic [15:0]      if_id_instr,
    output logic [15:0]      if_id_pc_plus2,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_events,
    output logic [CNT_W-1:0] flush_count
);

    fetch_state_t state, next_state;

    logic [15:0] pc, pc_d, pc_plus2;
    logic        pc_en;
    logic        ifid_en;
    logic [15:0] instr_d, ppc_d;
    logic        stall_inc, flush_inc;

    assign pc_plus2 = pc + 16'd2;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_RUN;
        else
            state <= next_state;
    end

    // Priority within RUN/STALL: hlt_in, then stall, then branch, then normal fetch.
    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        pc_d       = pc;
        ifid_en    = 1'b0;
        instr_d    = if_id_instr;
        ppc_d      = if_id_pc_plus2;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state)
            ST_RUN, ST_STALL: begin
                if (hlt_in) begin
                    next_state = ST_HALTED;
                end else if (stall) begin
                    next_state = ST_STALL;
                    stall_inc  = (state == ST_RUN);
                end else if (branch_taken) begin
                    pc_en      = 1'b1;
                    pc_d       = branch_target;
                    ifid_en    = 1'b1;
                    instr_d    = NOP_INSTR;
                    ppc_d      = branch_target;
                    flush_inc  = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    ifid_en = 1'b1;
                    instr_d = imem_instr;
                    ppc_d   = pc_plus2;
                    if (has_opcode(imem_instr, HLT_OPCODE)) begin
                        next_state = ST_DRAIN;
                    end else begin
                        pc_en      = 1'b1;
                        pc_d       = pc_plus2;
                        next_state = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                // HLT sits in IF/ID for the first drain cycle; every later edge loads NOP.
                ifid_en = 1'b1;
                instr_d = NOP_INSTR;
                if (hlt_in)
                    next_state = ST_HALTED;
            end
            default: begin
                next_state = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            halted <= 1'b0;
        else
            halted <= (next_state == ST_HALTED);
    end

    dff #(.W(16), .RST_VAL(RESET_PC)) u_pc (
        .clk (clk), .rst (rst), .en (pc_en), .d (pc_d), .q (pc)
    );

    dff #(.W(16), .RST_VAL(NOP_INSTR)) u_if_id_instr (
        .clk (clk), .rst (rst), .en (ifid_en), .d (instr_d), .q (if_id_instr)
    );

    dff #(.W(16), .RST_VAL(RESET_PC)) u_if_id_ppc (
        .clk (clk), .rst (rst), .en (ifid_en), .d (ppc_d), .q (if_id_pc_plus2)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk), .rst (rst), .en (stall_inc), .count (stall_events)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk), .rst (rst), .en (flush_inc), .count (flush_count)
    );

    assign id_ex_bubble = stall & ((state == ST_RUN) | (state == ST_STALL));
    assign imem_addr    = pc;
    assign state_o      = state;

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// Directed bench for if_id_fetch_ctrl: a driver issues one cycle of stimulus at a time
// and queues the hand-computed post-edge state; a monitor pops and compares after each edge.
module tb_if_id_fetch_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_DRAIN = 2'd2, S_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, hlt_in = 1'b0, branch_taken = 1'b0;
  logic [15:0] branch_target = '0, imem_instr = '0;
  logic [15:0] imem_addr, if_id_instr, if_id_pc_plus2;
  logic        id_ex_bubble, halted;
  logic [1:0]  state_o;
  logic [15:0] stall_events, flush_count;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
    logic [15:0] pp;
    logic [1:0]  st;
    logic        h;
    logic [15:0] se;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  if_id_fetch_ctrl dut (
    .clk (clk), .rst (rst), .stall (stall), .hlt_in (hlt_in),
    .branch_taken (branch_taken), .branch_target (branch_target),
    .imem_instr (imem_instr), .imem_addr (imem_addr),
    .if_id_instr (if_id_instr), .if_id_pc_plus2 (if_id_pc_plus2),
    .id_ex_bubble (id_ex_bubble), .halted (halted), .state_o (state_o),
    .stall_events (stall_events), .flush_count (flush_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // driver: inputs applied at negedge, combinational bubble checked before the edge
  task automatic step(input logic r, input logic st, input logic hl, input logic bt,
                      input logic [15:0] tgt, input logic [15:0] ins,
                      input logic [15:0] e_pc, input logic [15:0] e_ins, input logic [15:0] e_pp,
                      input logic [1:0] e_st, input logic e_h, input logic e_bub,
                      input logic [15:0] e_se, input logic [15:0] e_fc);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; hlt_in = hl; branch_taken = bt;
    branch_target = tgt; imem_instr = ins;
    #1;
    chk("id_ex_bubble", {15'd0, id_ex_bubble}, {15'd0, e_bub});
    e.pc = e_pc; e.ins = e_ins; e.pp = e_pp; e.st = e_st; e.h = e_h; e.se = e_se; e.fc = e_fc;
    exp_q.push_back(e);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("if_id_instr", if_id_instr, e.ins);
        chk("if_id_pc_plus2", if_id_pc_plus2, e.pp);
        chk("state_o", {14'd0, state_o}, {14'd0, e.st});
        chk("halted", {15'd0, halted}, {15'd0, e.h});
        chk("stall_events", stall_events, e.se);
        chk("flush_count", flush_count, e.fc);
      end
    end
  end

  initial begin
    //   rst st hl bt tgt       ins       | pc        ifid      pp        state  h  bub se  fc
    step(0, 0, 0, 0, 16'h0000, 16'h0000,  16'h0000, 16'h0000, 16'h0000, S_RUN,  0, 0, 0, 0);
    // sequential fetches from 0,2,4,6
    step(1, 0, 0, 0, 16'h0000, 16'h1000,  16'h0002, 16'h1000, 16'h0002, S_RUN,  0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 16'h1002,  16'h0004, 16'h1002, 16'h0004, S_RUN,  0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 16'h1004,  16'h0006, 16'h1004, 16'h0006, S_RUN,  0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 16'h1006,  16'h0008, 16'h1006, 16'h0008, S_RUN,  0, 0, 0, 0);
    // taken branch at 0x0008 -> 0x0040
    step(1, 0, 0, 1, 16'h0040, 16'h1008,  16'h0040, 16'h0000, 16'h0040, S_RUN,  0, 0, 0, 1);
    // branch with stall in the same cycle: stall wins, three stall cycles
    step(1, 1, 0, 1, 16'h0010, 16'h1040,  16'h0040, 16'h0000, 16'h0040, S_STALL,0, 1, 1, 1);
    step(1, 1, 0, 0, 16'h0000, 16'h1040,  16'h0040, 16'h0000, 16'h0040, S_STALL,0, 1, 1, 1);
    step(1, 1, 0, 0, 16'h0000, 16'h1040,  16'h0040, 16'h0000, 16'h0040, S_STALL,0, 1, 1, 1);
    // stall drops with a branch pending in STALL -> redirect to 0x0010
    step(1, 0, 0, 1, 16'h0010, 16'h1040,  16'h0010, 16'h0000, 16'h0010, S_RUN,  0, 0, 1, 2);
    // stall three cycles at 0x0010, then release fetches and advances to 0x0012
    step(1, 1, 0, 0, 16'h0000, 16'h1010,  16'h0010, 16'h0000, 16'h0010, S_STALL,0, 1, 2, 2);
    step(1, 1, 0, 0, 16'h0000, 16'h1010,  16'h0010, 16'h0000, 16'h0010, S_STALL,0, 1, 2, 2);
    step(1, 1, 0, 0, 16'h0000, 16'h1010,  16'h0010, 16'h0000, 16'h0010, S_STALL,0, 1, 2, 2);
    step(1, 0, 0, 0, 16'h0000, 16'h1010,  16'h0012, 16'h1010, 16'h0012, S_RUN,  0, 0, 2, 2);
    // branch to 0x0020, then fetch HLT there
    step(1, 0, 0, 1, 16'h0020, 16'h1012,  16'h0020, 16'h0000, 16'h0020, S_RUN,  0, 0, 2, 3);
    step(1, 0, 0, 0, 16'h0000, 16'hF000,  16'h0020, 16'hF000, 16'h0022, S_DRAIN,0, 0, 2, 3);
    // drain ignores stall and branch; bubble forced low
    step(1, 1, 0, 1, 16'h0100, 16'h1020,  16'h0020, 16'h0000, 16'h0022, S_DRAIN,0, 0, 2, 3);
    step(1, 1, 0, 0, 16'h0000, 16'h1020,  16'h0020, 16'h0000, 16'h0022, S_DRAIN,0, 0, 2, 3);
    step(1, 0, 1, 0, 16'h0000, 16'h1020,  16'h0020, 16'h0000, 16'h0022, S_HALT, 1, 0, 2, 3);
    // halted: everything frozen
    step(1, 1, 0, 1, 16'h0200, 16'h1234,  16'h0020, 16'h0000, 16'h0022, S_HALT, 1, 0, 2, 3);
    step(1, 0, 0, 0, 16'h0000, 16'h1234,  16'h0020, 16'h0000, 16'h0022, S_HALT, 1, 0, 2, 3);
    // reset out of HALTED
    step(0, 0, 0, 0, 16'h0000, 16'h1234,  16'h0000, 16'h0000, 16'h0000, S_RUN,  0, 0, 0, 0);
    // HLT at 0 -> DRAIN, then reset mid-drain
    step(1, 0, 0, 0, 16'h0000, 16'hF123,  16'h0000, 16'hF123, 16'h0002, S_DRAIN,0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 16'h1000,  16'h0000, 16'h0000, 16'h0002, S_DRAIN,0, 0, 0, 0);
    step(0, 0, 0, 0, 16'h0000, 16'h1000,  16'h0000, 16'h0000, 16'h0000, S_RUN,  0, 0, 0, 0);
    // HLT fetched with branch taken: HLT squashed, redirect
    step(1, 0, 0, 1, 16'h0030, 16'hF000,  16'h0030, 16'h0000, 16'h0030, S_RUN,  0, 0, 0, 1);
    // wrap at 0xFFFE
    step(1, 0, 0, 1, 16'hFFFE, 16'h1030,  16'hFFFE, 16'h0000, 16'hFFFE, S_RUN,  0, 0, 0, 2);
    step(1, 0, 0, 0, 16'h0000, 16'h2222,  16'h0000, 16'h2222, 16'h0000, S_RUN,  0, 0, 0, 2);
    // hlt_in from RUN outranks stall
    step(1, 1, 1, 0, 16'h0000, 16'h3333,  16'h0000, 16'h2222, 16'h0000, S_HALT, 1, 1, 0, 2);
    step(1, 0, 0, 0, 16'h0000, 16'h3333,  16'h0000, 16'h2222, 16'h0000, S_HALT, 1, 0, 0, 2);

    // final report
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
